// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: downstream control (stall / redirect), the
// instruction-memory request/response channel, and the IF/OF register outputs.
//   master : the fetch stage (drives imem_req/imem_addr and the IF/OF outputs)
//   slave  : pipeline + memory side (drives stall, redirect and responses)
interface instruction_fetch_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] Instruction;
    logic [31:0] pc_current;
    logic        if_valid;

    modport master (
        input  stall, branch_taken, branch_target, imem_rvalid, imem_rdata,
        output imem_req, imem_addr, Instruction, pc_current, if_valid
    );

    modport slave (
        output stall, branch_taken, branch_target, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr, Instruction, pc_current, if_valid
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction-fetch stage. Holds the fetch PC, keeps at most one request in
// flight to instruction memory, honours redirects and downstream stalls, and
// registers Instruction / pc_current / if_valid into the IF/OF boundary.
// Ports:
//   Clk    - clock, all state updates on the rising edge
//   Rst_n  - synchronous active-low reset
//   fif    - instruction_fetch_if.master (stall, redirect, imem channel,
//            IF/OF outputs)
//
// state | meaning
// FETCH | issue imem_req for fetch_pc this cycle
// WAIT  | one request outstanding, waiting for imem_rvalid
// HOLD  | response captured while stalled, waiting for stall to drop
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    instruction_fetch_if.master        fif
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      state, state_d;
    logic [31:0] fetch_pc, fetch_pc_d;
    logic        kill, kill_d;
    logic [31:0] hold_instr, hold_instr_d;
    logic [31:0] hold_pc, hold_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] target;

    assign target = fif.branch_target & 32'hFFFF_FFFC;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state      <= S_FETCH;
            fetch_pc   <= RESET_PC;
            kill       <= 1'b0;
            hold_instr <= 32'h0;
            hold_pc    <= 32'h0;
            instr_q    <= NOP_WORD;
            pc_q       <= 32'h0;
            valid_q    <= 1'b0;
        end else begin
            state      <= state_d;
            fetch_pc   <= fetch_pc_d;
            kill       <= kill_d;
            hold_instr <= hold_instr_d;
            hold_pc    <= hold_pc_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d      = state;
        fetch_pc_d   = fetch_pc;
        kill_d       = kill;
        hold_instr_d = hold_instr;
        hold_pc_d    = hold_pc;
        instr_d      = instr_q;
        pc_d         = pc_q;
        // No new instruction: hold under stall, otherwise insert a bubble.
        valid_d      = fif.stall ? valid_q : 1'b0;

        case (state)
            S_FETCH: begin
                state_d = S_WAIT;
                // The request for the old PC is already on the bus; its
                // response must be thrown away when it arrives.
                if (fif.branch_taken) begin
                    fetch_pc_d = target;
                    kill_d     = 1'b1;
                end
            end
            S_WAIT: begin
                if (fif.imem_rvalid) begin
                    state_d = S_FETCH;
                    if (kill || fif.branch_taken) begin
                        if (fif.branch_taken) begin
                            fetch_pc_d = target;
                        end
                        kill_d = 1'b0;
                    end else if (!fif.stall) begin
                        instr_d    = fif.imem_rdata;
                        pc_d       = fetch_pc;
                        valid_d    = 1'b1;
                        fetch_pc_d = fetch_pc + 32'd4;
                    end else begin
                        hold_instr_d = fif.imem_rdata;
                        hold_pc_d    = fetch_pc;
                        state_d      = S_HOLD;
                    end
                end else if (fif.branch_taken) begin
                    fetch_pc_d = target;
                    kill_d     = 1'b1;
                end
            end
            S_HOLD: begin
                if (fif.branch_taken) begin
                    fetch_pc_d = target;
                    state_d    = S_FETCH;
                end else if (!fif.stall) begin
                    instr_d    = hold_instr;
                    pc_d       = hold_pc;
                    valid_d    = 1'b1;
                    fetch_pc_d = fetch_pc + 32'd4;
                    state_d    = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // A redirect flushes whatever the output register would show next.
        if (fif.branch_taken) begin
            valid_d = 1'b0;
        end
    end

    assign fif.imem_req    = (state == S_FETCH) && Rst_n;
    assign fif.imem_addr   = fetch_pc;
    assign fif.Instruction = instr_q;
    assign fif.pc_current  = pc_q;
    assign fif.if_valid    = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch. A memory model answers one request at a time
// with a configurable latency and drops in-flight responses on reset. The
// reference model tracks the program-order PC stream: every new valid output
// must be the next PC of that stream (redirects restart it at the target),
// every request must be for that PC, and nothing may change under stall.
module tb_instruction_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_w;
    instruction_fetch_if ifa ();
    instruction_fetch_if ifw ();

    instruction_fetch dut (
        .Clk   (clk),
        .Rst_n (rst_a),
        .fif   (ifa)
    );

    instruction_fetch #(
        .RESET_PC (32'hFFFF_FFFC),
        .NOP_WORD (32'h0000_0000)
    ) dut_wrap (
        .Clk   (clk),
        .Rst_n (rst_w),
        .fif   (ifw)
    );

    bit          sel;
    logic        o_req, o_valid;
    logic [31:0] o_addr, o_instr, o_pc;

    assign o_req   = sel ? ifw.imem_req    : ifa.imem_req;
    assign o_addr  = sel ? ifw.imem_addr   : ifa.imem_addr;
    assign o_valid = sel ? ifw.if_valid    : ifa.if_valid;
    assign o_instr = sel ? ifw.Instruction : ifa.Instruction;
    assign o_pc    = sel ? ifw.pc_current  : ifa.pc_current;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc;
    logic [31:0] data_key;
    int          lat_min, lat_max;
    bit          pend;
    int          cnt;
    logic [31:0] pend_addr;
    int          nreq = 0;
    logic [31:0] last_req_addr;
    int          presented;
    logic        prev_valid;
    logic [31:0] prev_instr, prev_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic st, input logic br, input logic [31:0] tgt, input logic rst);
        logic        rv;
        logic [31:0] rd;
        @(negedge clk);
        ifa.stall = st;          ifw.stall = st;
        ifa.branch_taken = br;   ifw.branch_taken = br;
        ifa.branch_target = tgt; ifw.branch_target = tgt;
        rst_a = sel ? 1'b0 : rst;
        rst_w = sel ? rst : 1'b0;
        rv = 1'b0;
        rd = 32'h0;
        if (!rst) begin
            pend = 1'b0;
        end else if (pend) begin
            cnt--;
            if (cnt == 0) begin
                rv   = 1'b1;
                rd   = pend_addr ^ data_key;
                pend = 1'b0;
            end
        end
        ifa.imem_rvalid = rv; ifw.imem_rvalid = rv;
        ifa.imem_rdata  = rd; ifw.imem_rdata  = rd;
        #1;
        if (!rst) begin
            chk("req_in_reset", {31'b0, o_req}, 32'h0);
        end else if (o_req) begin
            chk("req_outstanding", {31'b0, pend}, 32'h0);
            chk("req_addr", o_addr, exp_pc);
            pend          = 1'b1;
            cnt           = $urandom_range(lat_max, lat_min);
            pend_addr     = o_addr;
            last_req_addr = o_addr;
            nreq++;
        end
        @(posedge clk);
        #1;
        if (!rst) begin
            chk("rst_valid", {31'b0, o_valid}, 32'h0);
            chk("rst_instr", o_instr, 32'h0);
            chk("rst_pc", o_pc, 32'h0);
            exp_pc = sel ? 32'hFFFF_FFFC : 32'h0;
        end else if (br) begin
            chk("flush_valid", {31'b0, o_valid}, 32'h0);
            chk("flush_instr", o_instr, prev_instr);
            chk("flush_pc", o_pc, prev_pc);
            exp_pc = tgt & 32'hFFFF_FFFC;
        end else if (st) begin
            chk("stall_valid", {31'b0, o_valid}, {31'b0, prev_valid});
            chk("stall_instr", o_instr, prev_instr);
            chk("stall_pc", o_pc, prev_pc);
        end else if (o_valid === 1'b1) begin
            chk("out_pc", o_pc, exp_pc);
            chk("out_instr", o_instr, exp_pc ^ data_key);
            exp_pc = exp_pc + 32'd4;
            presented++;
        end else begin
            chk("bubble_valid", {31'b0, o_valid}, 32'h0);
            chk("bubble_instr", o_instr, prev_instr);
            chk("bubble_pc", o_pc, prev_pc);
        end
        prev_valid = o_valid;
        prev_instr = o_instr;
        prev_pc    = o_pc;
    endtask

    task automatic run(input int n, input logic st);
        for (int i = 0; i < n; i++) cycle(st, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        presented = 0;
    endtask

    task automatic wait_valid(input string tag, input int limit);
        int k;
        k = 0;
        while (o_valid !== 1'b1 && k < limit) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            k++;
        end
        chk(tag, {31'b0, o_valid}, 32'h1);
    endtask

    initial begin
        int n0;
        logic st, br;
        sel = 1'b0;
        rst_a = 1'b0; rst_w = 1'b0;
        ifa.stall = 0; ifa.branch_taken = 0; ifa.branch_target = 0; ifa.imem_rvalid = 0; ifa.imem_rdata = 0;
        ifw.stall = 0; ifw.branch_taken = 0; ifw.branch_target = 0; ifw.imem_rvalid = 0; ifw.imem_rdata = 0;
        pend = 0; cnt = 0; pend_addr = 0; last_req_addr = 32'hDEAD_BEEF;
        exp_pc = 0; presented = 0; prev_valid = 0; prev_instr = 0; prev_pc = 0;

        // Straight-line fetch with 1-cycle memory, then a 5-cycle stall
        data_key = 32'h0; lat_min = 1; lat_max = 1;
        do_reset(2);
        run(4, 1'b0);
        chk("t1_presented", presented, 32'd2);
        chk("t1_pc4", o_pc, 32'h4);
        run(1, 1'b1);
        chk("t1_req8", last_req_addr, 32'h8);
        n0 = nreq;
        run(4, 1'b1);
        chk("t1_hold_pc", o_pc, 32'h4);
        chk("t1_hold_valid", {31'b0, o_valid}, 32'h1);
        run(1, 1'b0);
        chk("t1_pc8", o_pc, 32'h8);
        chk("t1_valid8", {31'b0, o_valid}, 32'h1);
        chk("t1_no_req_in_stall", nreq, n0);
        run(1, 1'b0);
        chk("t1_req12", last_req_addr, 32'hC);
        chk("t1_req_count", nreq, n0 + 1);

        // Redirect while waiting on a 3-cycle memory
        lat_min = 3; lat_max = 3;
        do_reset(1);
        run(5, 1'b0);
        chk("t2_req4", last_req_addr, 32'h4);
        cycle(1'b0, 1'b1, 32'h100, 1'b1);
        run(3, 1'b0);
        chk("t2_req100", last_req_addr, 32'h100);
        wait_valid("t2_wait", 10);
        chk("t2_pc100", o_pc, 32'h100);

        // Redirect while holding a stalled response
        lat_min = 1; lat_max = 1;
        do_reset(1);
        run(4, 1'b0);
        run(2, 1'b1);
        cycle(1'b1, 1'b1, 32'h203, 1'b1);
        chk("t3_flush", {31'b0, o_valid}, 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("t3_req200", last_req_addr, 32'h200);
        wait_valid("t3_wait", 10);
        chk("t3_pc200", o_pc, 32'h200);

        // PC wrap on the instance that starts at 0xFFFF_FFFC
        sel = 1'b1;
        do_reset(1);
        run(1, 1'b0);
        chk("t4_req_top", last_req_addr, 32'hFFFF_FFFC);
        run(2, 1'b0);
        chk("t4_req_wrap", last_req_addr, 32'h0);
        run(1, 1'b0);
        chk("t4_pc_wrap", o_pc, 32'h0);
        chk("t4_valid_wrap", {31'b0, o_valid}, 32'h1);
        sel = 1'b0;

        // Reset while a request is in flight
        data_key = 32'h1234_5678; lat_min = 3; lat_max = 3;
        do_reset(1);
        run(4, 1'b0);
        chk("t5_instr_pre", o_instr, 32'h1234_5678);
        run(1, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk("t5_valid", {31'b0, o_valid}, 32'h0);
        chk("t5_nop", o_instr, 32'h0);
        n0 = nreq;
        run(1, 1'b0);
        chk("t5_req_reset_pc", last_req_addr, 32'h0);
        chk("t5_req_count", nreq, n0 + 1);
        wait_valid("t5_wait", 10);
        chk("t5_pc0", o_pc, 32'h0);

        // Random stall / redirect / reset traffic with variable latency
        data_key = $urandom; lat_min = 1; lat_max = 4;
        do_reset(1);
        for (int i = 0; i < 600; i++) begin
            st = ($urandom_range(3, 0) == 0);
            br = ($urandom_range(11, 0) == 0);
            cycle(st, br, $urandom, ($urandom_range(99, 0) != 0));
        end
        chk("rand_progress", {31'b0, (presented > 10)}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
